// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 digest output path.
package sha256_pkg;

  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned NIBBLES  = 64;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_NEWLINE} streamer_state_t;

  // One output beat of the byte stream.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } stream_beat_t;

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational nibble to ASCII hex character.
//   nibble  : 4-bit value 0..15
//   ascii_c : '0'-'9', then 'a'-'f' (or 'A'-'F' when UPPERCASE)
module hex_ascii_enc
  import sha256_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  always_comb begin
    ascii_c = ASCII_0 + 8'(nibble);
    if (nibble > 4'd9) begin
      ascii_c = (UPPERCASE ? ASCII_UA : ASCII_LA) + 8'(nibble) - 8'd10;
    end
  end

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures a SHA-256 digest on the core's hash_valid pulse and streams it
// as 64 ASCII hex characters (MS nibble first) plus an optional newline,
// with valid/ready backpressure.
//   clk, rst_n     : clock, async active-low reset
//   enable         : gates acceptance of new digests only
//   hash_in        : digest, sampled when hash_valid_in=1
//   hash_valid_in  : one-cycle digest pulse
//   clear_overrun  : synchronous clear of overrun (set wins)
//   out_data/out_valid/out_ready/out_last : byte stream
//   busy           : stream in progress
//   overrun        : sticky, a digest was dropped while busy
module sha256_digest_streamer
  import sha256_pkg::*;
#(
  parameter bit APPEND_NL = 1'b1,
  parameter bit UPPERCASE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [255:0] hash_in,
  input  logic         hash_valid_in,
  input  logic         clear_overrun,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         overrun
);

  streamer_state_t       state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DIGEST_W-1:0]   shadow, shadow_n;
  stream_beat_t          beat_q, beat_n;
  logic                  valid_n, busy_n, overrun_n;

  logic                  hs_c, final_hs_c, accept_c, last_idx_c;
  logic [IDX_W-1:0]      nib_idx_c;
  logic [DIGEST_W-1:0]   nib_src_c;
  logic [7:0]            bit_hi_c;
  logic [3:0]            nibble_c;
  logic [7:0]            char_c;

  assign out_data = beat_q.data;
  assign out_last = beat_q.last;

  // Handshake terms; a new digest is taken in IDLE or on the final beat.
  assign hs_c       = out_valid & out_ready;
  assign final_hs_c = hs_c & beat_q.last;
  assign accept_c   = hash_valid_in & enable & ((state == ST_IDLE) | final_hs_c);
  assign last_idx_c = (idx == IDX_W'(NIBBLES - 1));

  // Nibble for the next presented character: first nibble of a new digest,
  // or the following nibble of the shadow copy.
  assign nib_idx_c = accept_c ? '0 : idx + IDX_W'(1);
  assign nib_src_c = accept_c ? hash_in : shadow;
  assign bit_hi_c  = 8'(DIGEST_W - 1) - {nib_idx_c, 2'b00};
  assign nibble_c  = nib_src_c[bit_hi_c -: 4];

  hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc (
    .nibble  (nibble_c),
    .ascii_c (char_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shadow_n  = shadow;
    beat_n    = beat_q;
    valid_n   = out_valid;
    overrun_n = overrun;

    if (accept_c) begin
      state_n     = ST_STREAM;
      idx_n       = '0;
      shadow_n    = hash_in;
      beat_n.data = char_c;
      beat_n.last = 1'b0;
      valid_n     = 1'b1;
    end else begin
      case (state)
        ST_STREAM: begin
          if (hs_c) begin
            if (last_idx_c) begin
              if (APPEND_NL) begin
                state_n     = ST_NEWLINE;
                beat_n.data = ASCII_NL;
                beat_n.last = 1'b1;
              end else begin
                state_n     = ST_IDLE;
                beat_n.last = 1'b0;
                valid_n     = 1'b0;
              end
            end else begin
              idx_n       = idx + IDX_W'(1);
              beat_n.data = char_c;
              beat_n.last = !APPEND_NL && (nib_idx_c == IDX_W'(NIBBLES - 1));
            end
          end
        end
        ST_NEWLINE: begin
          if (hs_c) begin
            state_n     = ST_IDLE;
            beat_n.last = 1'b0;
            valid_n     = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Drop while busy sets the sticky flag; set has priority over clear.
    if (hash_valid_in && busy && !accept_c) begin
      overrun_n = 1'b1;
    end else if (clear_overrun) begin
      overrun_n = 1'b0;
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      shadow    <= '0;
      beat_q    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      shadow    <= shadow_n;
      beat_q    <= beat_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// Scoreboard bench: instance 0 uses defaults (newline, lowercase),
// instance 1 uses UPPERCASE=1, APPEND_NL=0.
module tb_sha256_digest_streamer;
  import sha256_pkg::*;

  localparam logic [255:0] ABC_H =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_H =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7855b852;

  string abc_s = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
  string emp_s = "e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7855b852";
  string ff_s;

  logic         clk;
  logic         rst_n;
  logic         en   [2];
  logic [255:0] hin  [2];
  logic         hv   [2];
  logic         clr  [2];
  logic         rdy  [2];
  logic [7:0]   od   [2];
  logic         ov   [2];
  logic         ol   [2];
  logic         bsy  [2];
  logic         ovr  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt [2];

  stream_beat_t q0[$];
  stream_beat_t q1[$];

  logic       hold_p [2];
  logic [7:0] hold_d [2];
  logic       hold_l [2];

  sha256_digest_streamer dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .hash_in(hin[0]),
    .hash_valid_in(hv[0]), .clear_overrun(clr[0]), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(rdy[0]), .out_last(ol[0]),
    .busy(bsy[0]), .overrun(ovr[0])
  );

  sha256_digest_streamer #(.APPEND_NL(1'b0), .UPPERCASE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .hash_in(hin[1]),
    .hash_valid_in(hv[1]), .clear_overrun(clr[1]), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(rdy[1]), .out_last(ol[1]),
    .busy(bsy[1]), .overrun(ovr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int k, input string s, input bit nl);
    stream_beat_t b;
    for (int i = 0; i < 64; i++) begin
      b.data = s[i];
      b.last = (!nl && i == 63);
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
    if (nl) begin
      b.data = 8'h0A;
      b.last = 1'b1;
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Monitor: pops on every handshake, and checks hold during stalls.
  always @(negedge clk) begin
    stream_beat_t b;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        hold_p[k] = 1'b0;
      end else begin
        if (hold_p[k]) begin
          chk("stall_valid", 64'(ov[k]), 64'd1);
          chk("stall_data", 64'(od[k]), 64'(hold_d[k]));
          chk("stall_last", 64'(ol[k]), 64'(hold_l[k]));
        end
        if (ov[k] && rdy[k]) begin
          if (qsize(k) == 0) begin
            chk("unexpected_beat", 64'(od[k]), 64'hFFFF);
          end else begin
            b = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("beat_data", 64'(od[k]), 64'(b.data));
            chk("beat_last", 64'(ol[k]), 64'(b.last));
          end
          beat_cnt[k]++;
          hold_p[k] = 1'b0;
        end else if (ov[k]) begin
          hold_p[k] = 1'b1;
          hold_d[k] = od[k];
          hold_l[k] = ol[k];
        end else begin
          hold_p[k] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k, input logic [255:0] h, input string s,
                       input bit nl, input bit push);
    hv[k]  = 1'b1;
    hin[k] = h;
    if (push) push_exp(k, s, nl);
    tick();
    hv[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n = 0;
    while ((qsize(k) != 0 || ov[k]) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_beat(input int k, input int target, input int budget);
    int n = 0;
    while (beat_cnt[k] < target && n < budget) begin
      tick();
      n++;
    end
    chk("reach_beat", 64'(n < budget), 64'd1);
  endtask

  initial begin
    int base;
    int stall;
    int n;
    ff_s = "";
    for (int i = 0; i < 64; i++) ff_s = {ff_s, "F"};
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b1; hin[k] = '0; hv[k] = 1'b0; clr[k] = 1'b0; rdy[k] = 1'b1;
      beat_cnt[k] = 0; hold_p[k] = 1'b0;
    end
    tick(); tick();
    chk("rst_data", 64'(od[0]), 64'h0);
    chk("rst_valid", 64'(ov[0]), 64'h0);
    chk("rst_last", 64'(ol[0]), 64'h0);
    chk("rst_busy", 64'(bsy[0]), 64'h0);
    chk("rst_overrun", 64'(ovr[0]), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: abc digest, ready held high, one-cycle latency.
    base = beat_cnt[0];
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    chk("t1_latency_valid", 64'(ov[0]), 64'd1);
    chk("t1_first_char", 64'(od[0]), 64'h62);
    wait_drain(0, 200);
    chk("t1_busy_after", 64'(bsy[0]), 64'd0);
    chk("t1_beats", 64'(beat_cnt[0] - base), 64'd65);

    // 2: random backpressure with a 10-cycle stall on beat 30.
    base = beat_cnt[0];
    stall = 0;
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    n = 0;
    while ((q0.size() != 0 || ov[0]) && n < 2000) begin
      if (beat_cnt[0] - base == 30 && stall < 10) begin
        rdy[0] = 1'b0;
        stall++;
      end else begin
        rdy[0] = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    rdy[0] = 1'b1;
    chk("t2_drain_in_budget", 64'(n < 2000), 64'd1);
    chk("t2_stall_done", 64'(stall), 64'd10);

    // 3: overrun set, set-beats-clear, then clear.
    base = beat_cnt[0];
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    wait_beat(0, base + 20, 200);
    start(0, EMP_H, emp_s, 1'b1, 1'b0);
    chk("t3_overrun_set", 64'(ovr[0]), 64'd1);
    wait_drain(0, 200);
    chk("t3_overrun_sticky", 64'(ovr[0]), 64'd1);
    base = beat_cnt[0];
    start(0, EMP_H, emp_s, 1'b1, 1'b1);
    wait_beat(0, base + 5, 200);
    clr[0] = 1'b1;
    start(0, ABC_H, abc_s, 1'b1, 1'b0);
    clr[0] = 1'b0;
    chk("t3_set_wins", 64'(ovr[0]), 64'd1);
    wait_drain(0, 200);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("t3_cleared", 64'(ovr[0]), 64'd0);

    // 4: second digest exactly on the out_last handshake.
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    n = 0;
    while (!(ov[0] && ol[0]) && n < 200) begin
      tick();
      n++;
    end
    chk("t4_reach_last", 64'(n < 200), 64'd1);
    start(0, EMP_H, emp_s, 1'b1, 1'b1);
    chk("t4_no_idle", 64'(ov[0]), 64'd1);
    chk("t4_first_char", 64'(od[0]), 64'h65);
    chk("t4_last_low", 64'(ol[0]), 64'd0);
    chk("t4_no_overrun", 64'(ovr[0]), 64'd0);
    wait_drain(0, 200);

    // 5: enable low in IDLE ignores the pulse; dropping it mid-stream does not stop the stream.
    en[0] = 1'b0;
    start(0, ABC_H, abc_s, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("t5_ignored_valid", 64'(ov[0]), 64'd0);
    chk("t5_ignored_busy", 64'(bsy[0]), 64'd0);
    chk("t5_ignored_overrun", 64'(ovr[0]), 64'd0);
    en[0] = 1'b1;
    base = beat_cnt[0];
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    wait_beat(0, base + 5, 200);
    en[0] = 1'b0;
    wait_drain(0, 200);
    chk("t5_beats", 64'(beat_cnt[0] - base), 64'd65);
    en[0] = 1'b1;

    // 6: async reset mid-stream, then all-ones digest on the uppercase/no-NL instance.
    base = beat_cnt[0];
    start(0, ABC_H, abc_s, 1'b1, 1'b1);
    wait_beat(0, base + 10, 200);
    rst_n = 1'b0;
    #1;
    q0.delete();
    chk("t6_rst_data", 64'(od[0]), 64'h0);
    chk("t6_rst_valid", 64'(ov[0]), 64'h0);
    chk("t6_rst_last", 64'(ol[0]), 64'h0);
    chk("t6_rst_busy", 64'(bsy[0]), 64'h0);
    chk("t6_rst_overrun", 64'(ovr[0]), 64'h0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_resume", 64'(ov[0]), 64'd0);
    base = beat_cnt[1];
    start(1, '1, ff_s, 1'b0, 1'b1);
    chk("t6_first_upper", 64'(od[1]), 64'h46);
    wait_drain(1, 200);
    chk("t6_beats", 64'(beat_cnt[1] - base), 64'd64);
    chk("t6_busy_after", 64'(bsy[1]), 64'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_digest_streamer.md
Name: sha256_digest_streamer

Overview:
- Downstream stage of the SHA-256 core.
- Captures the 256-bit digest on the core's one-cycle hash_valid pulse and emits it as 64 ASCII hex characters, MS nibble first, plus an optional trailing newline.
- Output is a byte stream with valid/ready backpressure, feeding a UART TX or host FIFO.
- Decouples the core's pulse-style result from a slow consumer and flags digests dropped while busy.

Parameters:
- APPEND_NL, 1, when 1 a 0x0A byte follows the 64th hex char and carries out_last.
- UPPERCASE, 0, when 1 hex letters are 'A'-'F' (0x41-0x46); otherwise 'a'-'f' (0x61-0x66).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  when low, no new digest is accepted; a stream already in progress completes.
- hash_in  input  256  digest from the SHA-256 core; sampled only when hash_valid_in=1.
- hash_valid_in  input  1  one-cycle pulse marking hash_in valid.
- clear_overrun  input  1  synchronous clear of the overrun flag.
- out_data  output  8  ASCII byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the byte; a beat transfers when out_valid & out_ready.
- out_last  output  1  high on the final byte of a digest.
- busy  output  1  high in STREAM or NEWLINE.
- overrun  output  1  sticky; a digest pulse arrived while busy and was dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_data=8'h00, out_valid=0, out_last=0, busy=0, overrun=0, nibble index=0, shadow register=0.
  - Reset mid-stream aborts immediately; no partial completion after release.
- States:
  - IDLE: no stream.
  - STREAM: index 0..63 selects the current nibble.
  - NEWLINE: only reached when APPEND_NL=1.
- IDLE -> STREAM: on hash_valid_in=1 && enable=1.
  - hash_in is copied to the shadow register.
  - Next cycle: out_valid=1, out_data=char(hash_in[255:252]), index=0. Latency is 1 cycle.
  - hash_valid_in while enable=0 in IDLE is ignored; overrun is not set.
- STREAM:
  - Each handshake advances index; char k = enc(shadow[255-4k -: 4]).
  - Encoding: nibble 0-9 -> 0x30+n; 10-15 -> 0x61+n-10 (0x41+n-10 if UPPERCASE).
- Handshake of index 63:
  - APPEND_NL=1: go to NEWLINE, out_data=0x0A, out_last=1.
  - APPEND_NL=0: index 63 is presented with out_last=1; its handshake returns to IDLE.
- NEWLINE: handshake returns to IDLE, out_valid=0, out_last=0.
- Stability rule: while out_valid=1 && out_ready=0, out_data and out_last hold unchanged. out_valid never drops without a handshake; enable does not affect an active stream.
- Overrun:
  - hash_valid_in=1 while busy=1 sets overrun=1. The digest is dropped and the shadow register is untouched.
  - clear_overrun=1 clears overrun. If set and clear occur in the same cycle, set wins.
- Back-to-back case: if hash_valid_in=1 && enable=1 in the same cycle as the final-byte handshake (out_last beat):
  - The new digest is captured, with no overrun.
  - out_valid stays 1, and the next cycle presents the new digest's first char with index=0 and out_last=0.
- busy = (state != IDLE), registered. Throughput is 1 byte/cycle when out_ready is held high: 65 cycles per digest with NL, 64 without.

Decomposition:
- Shared package sha256_pkg:
  - DIGEST_W=256, NIBBLES=64.
  - ASCII_0=8'h30, ASCII_LA=8'h61, ASCII_UA=8'h41, ASCII_NL=8'h0A.
  - typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_NEWLINE} streamer_state_t.
- One sub-module: hex_ascii_enc.
  - Combinational nibble -> ASCII with an UPPERCASE parameter.
  - Instantiated once on the muxed nibble.

Test Plan:
1. Digest of "abc" (ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad), out_ready=1, APPEND_NL=1 -> 65 consecutive beats: first 0x62 'b', second 0x61 'a', 64th 0x64 'd', 65th 0x0A with out_last=1; busy low the cycle after.
2. Same digest with out_ready toggling randomly, plus a 10-cycle stall on beat 30 -> out_data/out_last stable through every stall; byte sequence identical to test 1.
3. Pulse hash_valid_in at beat 20 of an active stream -> overrun=1, remaining bytes still from the first digest. Then clear_overrun and a pulse together -> overrun stays 1. Then clear_overrun alone -> overrun=0.
4. Second digest pulsed exactly on the out_last handshake -> no idle cycle; next byte is the first char of the second digest; overrun=0.
5. enable=0 with a hash_valid_in pulse in IDLE -> no output and overrun=0. Drop enable mid-stream -> stream completes all 65 bytes.
6. rst_n low at beat 10, held 3 cycles -> all outputs 0 immediately (async). After release, a new digest 0xFFFF...FF with UPPERCASE=1, APPEND_NL=0 -> 64 bytes of 0x46, out_last on the 64th.
